// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared encodings and helpers for the M-extension mul/div unit
package ula_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_CALC = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Wide enough for the 2*XLEN product at XLEN=64; callers truncate with a size cast.
  localparam int NEG_W = 128;

  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] v, input logic en);
    return en ? (~v + NEG_W'(1)) : v;
  endfunction

endpackage

// File: rtl/ula_muldiv.sv
// rtl/ula_muldiv.sv - iterative radix-2 multiply / restoring-divide unit for RV32M/RV64M
module ula_muldiv
  import ula_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam int AW = 2*XLEN + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sa_q, sa_d, sb_q, sb_d, dz_q, dz_d, ov_q, ov_d;

  logic            signed_a, signed_b, is_div, is_rem;
  logic            a_neg, b_neg, dz_now, ov_now;
  logic [XLEN-1:0] mag_a, mag_b, quo_fix, rem_fix, fix_res;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN:0]   mul_sum;
  logic [AW-1:0]   div_sh;
  logic [XLEN+1:0] div_diff;

  always_comb begin
    signed_a = (f3_q == MD_MULH) || (f3_q == MD_MULHSU) || (f3_q == MD_DIV) || (f3_q == MD_REM);
    signed_b = (f3_q == MD_MULH) || (f3_q == MD_DIV) || (f3_q == MD_REM);
    is_div   = f3_q[2];
    is_rem   = f3_q[2] & f3_q[1];
    a_neg    = signed_a & a_q[XLEN-1];
    b_neg    = signed_b & b_q[XLEN-1];
    mag_a    = XLEN'(cond_neg(NEG_W'(a_q), a_neg));
    mag_b    = XLEN'(cond_neg(NEG_W'(b_q), b_neg));
    dz_now   = is_div && (b_q == '0);
    ov_now   = is_div && signed_b && (a_q == MIN_INT) && (b_q == '1);

    // In mul mode b_q holds the multiplicand; in div mode it holds the divisor magnitude.
    mul_sum  = acc_q[2*XLEN:XLEN] + {1'b0, b_q};
    div_sh   = {acc_q[AW-2:0], 1'b0};
    div_diff = {1'b0, div_sh[2*XLEN:XLEN]} - {2'b00, b_q};

    prod_fix = (2*XLEN)'(cond_neg(NEG_W'(acc_q[2*XLEN-1:0]), sa_q ^ sb_q));
    quo_fix  = XLEN'(cond_neg(NEG_W'(acc_q[XLEN-1:0]), sa_q ^ sb_q));
    rem_fix  = XLEN'(cond_neg(NEG_W'(acc_q[2*XLEN-1:XLEN]), sa_q));

    if (dz_q)        fix_res = is_rem ? a_q : '1;
    else if (ov_q)   fix_res = is_rem ? '0 : a_q;
    else if (is_div) fix_res = is_rem ? rem_fix : quo_fix;
    else             fix_res = (f3_q == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          f3_d    = funct3;
          a_d     = op_a;
          b_d     = op_b;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        sa_d    = a_neg;
        sb_d    = b_neg;
        dz_d    = dz_now;
        ov_d    = ov_now;
        b_d     = is_div ? mag_b : mag_a;
        acc_d   = {{(XLEN+1){1'b0}}, (is_div ? mag_a : mag_b)};
        cnt_d   = CW'(XLEN-1);
        state_d = (dz_now || ov_now) ? ST_FIX : ST_CALC;
      end
      ST_CALC: begin
        if (is_div) begin
          if (div_diff[XLEN+1]) acc_d = div_sh;
          else                  acc_d = {div_diff[XLEN:0], div_sh[XLEN-1:1], 1'b1};
        end else begin
          acc_d = {1'b0, (acc_q[0] ? mul_sum : acc_q[2*XLEN:XLEN]), acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        res_d   = fix_res;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A completed op still retires in FIX, so flush only overrides the state transition.
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_FIX);
  assign result = (state_q == ST_FIX) ? fix_res : res_q;

endmodule

// File: tb/tb_ula_muldiv.sv
// tb/tb_ula_muldiv.sv - scoreboard bench for ula_muldiv at XLEN=32
module tb_ula_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] last_res = '0;

  ula_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub_s, p;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub_s = {32'd0, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub_s; return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 2;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
    return 34;
  endfunction

  // Issues one op starting at the next negedge (cycle 0) and waits for done, bounded.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy_cnt, output bit got);
    got = 0; lat = 0; busy_cnt = 0; res = '0;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin got = 1; lat = cyc; res = result; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h expected 00000000", result); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] e; int l; } vec_t;

  task automatic test_directed;
    vec_t tbl[12];
    logic [31:0] res, exp;
    int lat, bc, elat;
    bit got;
    tbl[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    tbl[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    tbl[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34};
    tbl[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    tbl[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    tbl[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    tbl[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       34};
    tbl[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        34};
    tbl[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 2};
    tbl[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        2};
    tbl[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    tbl[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2};
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(tbl[i].e);
      lat_q.push_back(tbl[i].l);
      do_op(tbl[i].f, tbl[i].a, tbl[i].b, res, lat, bc, got);
      exp = exp_q.pop_front();
      elat = lat_q.pop_front();
      checks++;
      if (!got) begin failures++; $display("FAIL dir%0d_timeout: no done within 60 cycles", i); end
      else begin
        if (res !== exp) begin failures++; $display("FAIL dir%0d_result: got %h expected %h", i, res, exp); end
        checks++;
        if (lat != elat) begin failures++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, elat); end
        checks++;
        if (bc != elat) begin failures++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, elat); end
        last_res = exp;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res, exp;
    int lat, bc, elat;
    bit got;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ref_model(3'd5, 32'd1000 + i, 32'd3));
      lat_q.push_back(34);
      do_op(3'd5, 32'd1000 + i, 32'd3, res, lat, bc, got);
      exp = exp_q.pop_front();
      elat = lat_q.pop_front();
      checks++;
      if (!got || res !== exp || lat != elat) begin
        failures++;
        $display("FAIL b2b%0d: got %h lat %0d expected %h lat %0d", i, res, lat, exp, elat);
      end
      if (got) last_res = res;
    end
  endtask

  task automatic test_start_ignored;
    int dones = 0;
    logic [31:0] res = '0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFFFFFD;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 5) begin start = 1'b1; funct3 = 3'd5; op_a = 32'd5; op_b = 32'd0; end
      if (done) begin dones++; res = result; end
    end
    checks++;
    if (dones != 1) begin failures++; $display("FAIL ignored_start_dones: got %0d expected 1", dones); end
    checks++;
    if (res !== 32'hFFFFFFEB) begin failures++; $display("FAIL ignored_start_result: got %h expected FFFFFFEB", res); end
    last_res = 32'hFFFFFFEB;
  endtask

  task automatic test_flush;
    int dones = 0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd9;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 10) flush = 1'b1;
      if (cyc == 11) begin
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b expected 0", busy); end
      end
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin failures++; $display("FAIL flush_done: got %0d expected 0", dones); end
    checks++;
    if (result !== last_res) begin failures++; $display("FAIL flush_result: got %h expected %h", result, last_res); end
  endtask

  task automatic test_flush_at_done;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; op_a = 32'd5; op_b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL flushdone_pulse: got %b expected 1", done); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL flushdone_after: busy %b result %h expected busy 0 result FFFFFFFF", busy, result);
    end
    last_res = 32'hFFFFFFFF;
  endtask

  task automatic test_flush_start_idle;
    int dones = 0;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd5; op_a = 32'd9; op_b = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL flushstart_busy: got %b expected 0", busy); end
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin failures++; $display("FAIL flushstart_done: got %0d expected 0", dones); end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd3; op_a = 32'h12345678; op_b = 32'h9ABCDEF0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      failures++; $display("FAIL reset_mid: busy %b done %b result %h expected 0 0 00000000", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin failures++; $display("FAIL reset_mid_done: got %0d expected 0", dones); end
    last_res = '0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [31:0] a, b, res, exp;
    logic [2:0] f;
    int lat, bc, elat, bad = 0;
    bit got;
    for (int i = 0; i < 1200; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp_q.push_back(ref_model(f, a, b));
      lat_q.push_back(ref_lat(f, a, b));
      do_op(f, a, b, res, lat, bc, got);
      exp = exp_q.pop_front();
      elat = lat_q.pop_front();
      checks++;
      if (!got || res !== exp || lat != elat) begin
        failures++;
        if (bad < 10) $display("FAIL rand%0d f=%0d a=%h b=%h: got %h lat %0d expected %h lat %0d",
                               i, f, a, b, res, lat, exp, elat);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_ignored();
    test_flush();
    test_flush_at_done();
    test_flush_start_idle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
